// File: rtl/u_fetch_pc_pkg.sv
// Shared widths, reset default and bubble-decode helper for the fetch PC tracker.
`timescale 1ns/1ps
package u_fetch_pc_pkg;
  localparam int XLEN    = 32;
  localparam int PC_W    = 31;
  localparam int WADDR_W = 30;
  localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'h0000_0000;

  // Upper half-word start with no word advance and no next-word fetch is the
  // first half of a split 32-bit instruction: fetch emits a NOP that cycle.
  function automatic logic is_split_bubble(input logic cnt_sel, input logic addr_sel,
                                           input logic aligned_n);
    return aligned_n & ~addr_sel & ~cnt_sel;
  endfunction
endpackage

// File: rtl/u_fetch_pc.sv
// Fetch word-address generator and byte-PC tracker running in lock-step with fetch.
`timescale 1ns/1ps
module u_fetch_pc
  import u_fetch_pc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 data_busywait_i,
  input  logic                 stall_i,
  input  logic                 branching_i,
  input  logic [PC_W-1:0]      branch_target_i,
  input  logic                 fetch_counter_sel_i,
  input  logic                 fetch_address_sel_i,
  input  logic                 pc_aligned_n_sel_i,
  input  logic                 is_long_i,
  output logic [WADDR_W-1:0]   fetch_addr_o,
  output logic                 branch_aligned_n_o,
  output logic [PC_W-1:0]      pc_o,
  output logic [PC_W-1:0]      pc_next_o,
  output logic                 pc_valid_o,
  output logic [XLEN-1:0]      issue_count_o
);

  logic [WADDR_W-1:0] r_fetch_counter;
  logic [PC_W-1:0]    r_pc;
  logic               r_valid;
  logic [XLEN-1:0]    r_count;

  logic               w_adv;
  logic               w_issue;
  logic [WADDR_W-1:0] w_counter_inc;

  assign w_adv         = ~data_busywait_i & ~stall_i;
  assign w_counter_inc = r_fetch_counter + WADDR_W'(1);
  // An instruction is issued only on a non-branch advance that is not a split bubble.
  assign w_issue       = w_adv & ~branching_i &
                         ~is_split_bubble(fetch_counter_sel_i, fetch_address_sel_i,
                                          pc_aligned_n_sel_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fetch_counter <= RESET_VECTOR[XLEN-1:2];
      r_pc            <= RESET_VECTOR[XLEN-1:1];
      r_valid         <= 1'b0;
      r_count         <= '0;
    end else begin
      r_valid <= w_issue;
      if (w_issue) r_count <= r_count + XLEN'(1);
      if (w_adv) begin
        if (branching_i) begin
          r_fetch_counter <= branch_target_i[PC_W-1:1];
        end else begin
          if (fetch_counter_sel_i) r_fetch_counter <= w_counter_inc;
          r_pc <= {r_fetch_counter, pc_aligned_n_sel_i};
        end
      end
    end
  end

  assign fetch_addr_o       = fetch_address_sel_i ? w_counter_inc : r_fetch_counter;
  assign branch_aligned_n_o = branch_target_i[0];
  assign pc_o               = r_pc;
  assign pc_next_o          = r_pc + (is_long_i ? PC_W'(2) : PC_W'(1));
  assign pc_valid_o         = r_valid;
  assign issue_count_o      = r_count;

endmodule

// File: tb/tb_u_fetch_pc.sv
// Directed plus randomized checks of u_fetch_pc against a byte-address reference model.
`timescale 1ns/1ps
module tb_u_fetch_pc;
  localparam logic [31:0] RV = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy = 1'b0, stall = 1'b0, br = 1'b0;
  logic [30:0] tgt = '0;
  logic        csel = 1'b0, asel = 1'b0, nsel = 1'b0, islong = 1'b0;
  logic [29:0] fetch_addr;
  logic        br_al_n;
  logic [30:0] pc, pc_next;
  logic        pc_valid;
  logic [31:0] icount;

  int checks = 0;
  int failures = 0;

  // Reference model kept in byte addresses.
  logic [31:0] m_word_byte;
  logic [31:0] m_pc_byte;
  logic        m_valid;
  logic [31:0] m_cnt;

  u_fetch_pc #(.RESET_VECTOR(RV)) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_busywait_i(busy), .stall_i(stall),
    .branching_i(br), .branch_target_i(tgt), .fetch_counter_sel_i(csel),
    .fetch_address_sel_i(asel), .pc_aligned_n_sel_i(nsel), .is_long_i(islong),
    .fetch_addr_o(fetch_addr), .branch_aligned_n_o(br_al_n), .pc_o(pc),
    .pc_next_o(pc_next), .pc_valid_o(pc_valid), .issue_count_o(icount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_word_byte = {RV[31:2], 2'b00};
    m_pc_byte   = {RV[31:1], 1'b0};
    m_valid     = 1'b0;
    m_cnt       = 0;
  endtask

  task automatic check_comb();
    logic [31:0] fa_byte, pn_byte;
    fa_byte = m_word_byte + (asel ? 32'd4 : 32'd0);
    pn_byte = m_pc_byte + (islong ? 32'd4 : 32'd2);
    chk("fetch_addr", {2'b00, fetch_addr}, {2'b00, fa_byte[31:2]});
    chk("branch_aligned_n", {31'd0, br_al_n}, {31'd0, tgt[0]});
    chk("pc_next", {1'b0, pc_next}, {1'b0, pn_byte[31:1]});
  endtask

  task automatic check_regs();
    chk("pc", {1'b0, pc}, {1'b0, m_pc_byte[31:1]});
    chk("pc_valid", {31'd0, pc_valid}, {31'd0, m_valid});
    chk("issue_count", icount, m_cnt);
  endtask

  // One clock with the given inputs; the model follows the written rules in byte terms.
  task automatic step(input logic b, input logic s, input logic r, input logic [30:0] t,
                      input logic c, input logic a, input logic n, input logic l);
    busy = b; stall = s; br = r; tgt = t; csel = c; asel = a; nsel = n; islong = l;
    #1 check_comb();
    @(posedge clk);
    if (!b && !s) begin
      if (r) begin
        m_word_byte = {t, 1'b0} & 32'hFFFF_FFFC;
        m_valid = 1'b0;
      end else begin
        m_pc_byte   = m_word_byte + (n ? 32'd2 : 32'd0);
        m_word_byte = m_word_byte + (c ? 32'd4 : 32'd0);
        m_valid     = !(n && !a && !c);
        if (m_valid) m_cnt = m_cnt + 1;
      end
    end else begin
      m_valid = 1'b0;
    end
    #1 check_regs();
    $display("step busy=%0b stall=%0b br=%0b tgt=%h sel=%0b%0b%0b pc=%h valid=%0b cnt=%0d faddr=%h",
             b, s, r, t, c, a, n, pc, pc_valid, icount, fetch_addr);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_fetch_addr", {2'b00, fetch_addr}, 32'h400);
    chk("rst_pc", {1'b0, pc}, 32'h800);
    chk("rst_valid", {31'd0, pc_valid}, 32'd0);
    chk("rst_count", icount, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two compressed instructions in word 0x400.
    step(0, 0, 0, '0, 0, 0, 0, 0);
    chk("tp1_pc", {1'b0, pc}, 32'h800);
    chk("tp1_valid", {31'd0, pc_valid}, 32'd1);
    step(0, 0, 0, '0, 1, 0, 1, 0);
    chk("tp2_pc", {1'b0, pc}, 32'h801);
    chk("tp2_faddr", {2'b00, fetch_addr}, 32'h401);
    chk("tp2_count", icount, 32'd2);

    // Branch to byte 0x2002.
    tgt = 31'h1001;
    #1 chk("tp3_br_al", {31'd0, br_al_n}, 32'd1);
    step(0, 0, 1, 31'h1001, 0, 0, 0, 0);
    chk("tp3_faddr", {2'b00, fetch_addr}, 32'h800);
    chk("tp3_valid", {31'd0, pc_valid}, 32'd0);

    // Split long instruction at 0x2002.
    step(0, 0, 0, '0, 0, 0, 1, 1);
    chk("tp4_bubble", {31'd0, pc_valid}, 32'd0);
    step(0, 0, 0, '0, 1, 1, 1, 1);
    chk("tp4_pc", {1'b0, pc}, 32'h1001);
    chk("tp4_pc_next", {1'b0, pc_next}, 32'h1003);
    chk("tp4_valid", {31'd0, pc_valid}, 32'd1);

    // Busywait for 3 cycles with a branch pulsed.
    step(1, 0, 0, '0, 1, 0, 0, 0);
    step(1, 0, 1, 31'h0123_4560, 1, 0, 0, 0);
    step(1, 0, 0, '0, 1, 0, 0, 0);
    chk("tp5_faddr", {2'b00, fetch_addr}, 32'h801);

    // Counter wrap at the top of the address space.
    step(0, 0, 1, 31'h7FFF_FFFE, 0, 0, 0, 0);
    step(0, 0, 0, '0, 0, 1, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0, 0);
    chk("wrap_faddr", {2'b00, fetch_addr}, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic [30:0] rt;
      rt = 31'($urandom);
      if ($urandom_range(0, 15) == 0) rt[30:2] = 29'h1FFF_FFFF;
      step($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0, rt,
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Async reset mid-stream at counter 0x7FF.
    step(0, 0, 1, 31'h0FFE, 0, 0, 0, 0);
    step(0, 0, 0, '0, 0, 0, 0, 0);
    chk("pre_rst_faddr", {2'b00, fetch_addr}, 32'h7FF);
    #2 rst_n = 1'b0;
    busy = 0; stall = 0; br = 0; asel = 0;
    #1;
    model_reset();
    chk("arst_faddr", {2'b00, fetch_addr}, 32'h400);
    chk("arst_pc", {1'b0, pc}, 32'h800);
    chk("arst_valid", {31'd0, pc_valid}, 32'd0);
    chk("arst_count", icount, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, '0, 0, 0, 0, 0);
    chk("post_rst_valid", {31'd0, pc_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
